// File: rtl/command_hub_pkg.sv
// rtl/command_hub_pkg.sv - shared types and default constants for the command hub
// Purpose: FSM state enum, operation-type enum, default parameter values and
//          a small constant helper used to size the hold counter.
// Ports:   none (package).
package command_hub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RST,
    ST_ADDR,
    ST_WRITE
  } state_e;

  typedef enum logic {
    OP_ADDR,
    OP_WRITE
  } op_e;

  localparam int DEF_N_SRC      = 2;
  localparam int DEF_AW         = 8;
  localparam int DEF_DW         = 8;
  localparam int DEF_RST_CYCLES = 50000;
  localparam int DEF_AD_CYCLES  = 3;
  localparam int DEF_SW_CYCLES  = 3;
  localparam logic [7:0] DEF_SOFT_RST_ADDR = 8'h01;
  localparam logic [7:0] DEF_SOFT_RST_DATA = 8'h02;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/command_hub_if.sv
// rtl/command_hub_if.sv - per-source request/acknowledge bundle of the command hub
// Purpose: groups the level request lines, operands and ack pulses of all sources.
// Ports:   src_we_addr/src_write (N_SRC level requests), src_addr (N_SRC*AW),
//          src_data (N_SRC*DW), src_ack (N_SRC one-cycle completion pulses).
// Modports: master = command sources, slave = hub.
interface command_hub_if
  import command_hub_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
);

  logic [N_SRC-1:0]    src_we_addr;
  logic [N_SRC*AW-1:0] src_addr;
  logic [N_SRC-1:0]    src_write;
  logic [N_SRC*DW-1:0] src_data;
  logic [N_SRC-1:0]    src_ack;

  modport master (
    output src_we_addr, src_addr, src_write, src_data,
    input  src_ack
  );

  modport slave (
    input  src_we_addr, src_addr, src_write, src_data,
    output src_ack
  );

endinterface

// File: rtl/command_hub_arbiter.sv
// rtl/command_hub_arbiter.sv - source arbiter (module cmd_rr_arbiter)
// Purpose: picks one requesting source and returns a one-hot grant.
//          COMMAND_HUB_RR_EN defined: round robin, the pointer moves to the
//          source after the last granted one when advance is high.
//          COMMAND_HUB_RR_EN undefined: fixed priority, lowest index wins.
// Ports:   clk, reset (async active-low), req[N_SRC], advance, grant[N_SRC].
module cmd_rr_arbiter #(
  parameter int N_SRC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             advance,
  output logic [N_SRC-1:0] grant
);

`ifdef COMMAND_HUB_RR_EN
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            best;
  int            best_dist;
  int            dist;

  // Winner is the requester at the smallest circular distance from the pointer.
  always_comb begin
    best      = 0;
    best_dist = N_SRC;
    dist      = 0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) begin
        dist = i - int'(ptr_q);
        if (dist < 0) dist = dist + N_SRC;
        if (dist < best_dist) begin
          best_dist = dist;
          best      = i;
        end
      end
    end
    grant = '0;
    for (int i = 0; i < N_SRC; i++) begin
      grant[i] = (best_dist < N_SRC) && (best == i);
    end
    ptr_d = ptr_q;
    if (advance && (best_dist < N_SRC)) begin
      ptr_d = (best == N_SRC - 1) ? '0 : PW'(best + 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Scan from the top so the lowest requesting index is the last writer.
  always_comb begin
    grant = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/command_hub.sv
// rtl/command_hub.sv - multi-source register command hub with soft-reset pulse
// Purpose: arbitrates address-write and data-write requests from N_SRC sources,
//          holds addr for AD_CYCLES, strobes sw_out for SW_CYCLES, and emits a
//          RST_CYCLES reset_out pulse when addr/data_out hit the trigger pair.
// Ports:   clk, reset (async active-low), init, bus (command_hub_if.slave),
//          addr[AW], data_out[DW], sw_out, reset_out, busy.
// Config:  COMMAND_HUB_RR_EN selects round-robin arbitration (see cmd_rr_arbiter).
module command_hub
  import command_hub_pkg::*;
#(
  parameter int N_SRC      = DEF_N_SRC,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int AD_CYCLES  = DEF_AD_CYCLES,
  parameter int SW_CYCLES  = DEF_SW_CYCLES,
  parameter logic [AW-1:0] SOFT_RST_ADDR = AW'(DEF_SOFT_RST_ADDR),
  parameter logic [DW-1:0] SOFT_RST_DATA = DW'(DEF_SOFT_RST_DATA)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  command_hub_if.slave  bus,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_out,
  output logic          sw_out,
  output logic          reset_out,
  output logic          busy
);

  localparam int CW = $clog2(max3(RST_CYCLES, AD_CYCLES, SW_CYCLES) + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             sw_q, sw_d;
  logic             rst_out_q, rst_out_d;
  logic             busy_q, busy_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] gnt;
  logic             advance;
  logic             soft_hit;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             sel_is_addr;
  op_e              grant_op;

  assign req      = bus.src_we_addr | bus.src_write;
  assign soft_hit = (addr_q == SOFT_RST_ADDR) && (data_q == SOFT_RST_DATA);
  // Only a genuine grant moves the round-robin pointer.
  assign advance  = (state_q == ST_IDLE) && !init && !soft_hit && (|req);

  cmd_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .grant   (gnt)
  );

  always_comb begin
    sel_addr    = '0;
    sel_data    = '0;
    sel_is_addr = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr    = bus.src_addr[i*AW +: AW];
        sel_data    = bus.src_data[i*DW +: DW];
        sel_is_addr = bus.src_we_addr[i];
      end
    end
  end

  // A source with both requests gets its address op first; the write stays pending.
  assign grant_op = sel_is_addr ? OP_ADDR : OP_WRITE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sw_d      = sw_q;
    rst_out_d = rst_out_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (init) begin
          state_d = ST_INIT;
          addr_d  = '0;
        end else if (soft_hit) begin
          state_d   = ST_RST;
          addr_d    = '0;
          data_d    = '0;
          rst_out_d = 1'b1;
          cnt_d     = CW'(RST_CYCLES - 1);
        end else if (advance) begin
          gnt_d = gnt;
          if (grant_op == OP_ADDR) begin
            state_d = ST_ADDR;
            addr_d  = sel_addr;
            cnt_d   = CW'(AD_CYCLES - 1);
            if (AD_CYCLES == 1) ack_d = gnt;
          end else begin
            state_d = ST_WRITE;
            data_d  = sel_data;
            sw_d    = 1'b1;
            cnt_d   = CW'(SW_CYCLES - 1);
            if (SW_CYCLES == 1) ack_d = gnt;
          end
        end
      end
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_RST: begin
        if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          rst_out_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ADDR: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // ack is registered, so raise it one cycle ahead of the final hold cycle
          if (cnt_q == CW'(1)) ack_d = gnt_q;
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          sw_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) ack_d = gnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sw_q      <= 1'b0;
      rst_out_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sw_q      <= sw_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      gnt_q     <= gnt_d;
    end
  end

  assign addr        = addr_q;
  assign data_out    = data_q;
  assign sw_out      = sw_q;
  assign reset_out   = rst_out_q;
  assign busy        = busy_q;
  assign bus.src_ack = ack_q;

endmodule

// File: tb/tb_command_hub.sv
// tb/tb_command_hub.sv - self-checking bench for command_hub
module tb_command_hub;

  localparam int NS  = 2;
  localparam int CYC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       sw_out;
  logic       reset_out;
  logic       busy;

  command_hub_if #(.N_SRC(NS), .AW(8), .DW(8)) bus_if ();

  command_hub #(
    .N_SRC(NS), .AW(8), .DW(8),
    .RST_CYCLES(16), .AD_CYCLES(CYC), .SW_CYCLES(CYC),
    .SOFT_RST_ADDR(8'h01), .SOFT_RST_DATA(8'h02)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .bus       (bus_if),
    .addr      (addr),
    .data_out  (data_out),
    .sw_out    (sw_out),
    .reset_out (reset_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         rr_next = 0;
  bit         ad_p [NS];
  bit         wr_p [NS];
  logic [7:0] av [NS];
  logic [7:0] dv [NS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: which pending source is served next.
  function automatic int pick_src();
    for (int k = 0; k < NS; k++) begin
      int s;
`ifdef COMMAND_HUB_RR_EN
      s = (rr_next + k) % NS;
`else
      s = k;
`endif
      if (ad_p[s] || wr_p[s]) return s;
    end
    return -1;
  endfunction

  function automatic void note_grant(input int s);
    rr_next = (s + 1) % NS;
  endfunction

  task automatic wait_ack(output int lat, output logic [1:0] ackv);
    lat  = 0;
    ackv = 2'b00;
    while (ackv == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
      ackv = bus_if.src_ack;
    end
  endtask

  // One isolated op from idle; checks every hold cycle and the return to idle.
  task automatic run_single(input int s, input bit is_addr, input logic [7:0] val, input bit drop_early);
    logic [1:0] oh;
    oh = 2'(1 << s);
    if (is_addr) begin
      bus_if.src_addr[s*8 +: 8] = val;
      bus_if.src_we_addr[s]     = 1'b1;
    end else begin
      bus_if.src_data[s*8 +: 8] = val;
      bus_if.src_write[s]       = 1'b1;
    end
    note_grant(s);
    for (int k = 1; k <= CYC; k++) begin
      @(negedge clk);
      check("op_busy", busy, 1);
      check("op_ack", bus_if.src_ack, (k == CYC) ? oh : 2'b00);
      if (is_addr) begin
        check("op_addr", addr, val);
        check("op_sw_low", sw_out, 0);
      end else begin
        check("op_data", data_out, val);
        check("op_sw_high", sw_out, 1);
      end
      if (k == 1) begin
        bus_if.src_addr[s*8 +: 8] = ~val;
        bus_if.src_data[s*8 +: 8] = ~val;
        if (drop_early) begin
          bus_if.src_we_addr[s] = 1'b0;
          bus_if.src_write[s]   = 1'b0;
        end
      end
    end
    bus_if.src_we_addr[s] = 1'b0;
    bus_if.src_write[s]   = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ack", bus_if.src_ack, 0);
    check("idle_sw", sw_out, 0);
  endtask

  initial begin
    int         lat;
    int         cnt;
    int         s;
    bit         is_a;
    bit         first;
    logic [1:0] ackv;
    logic [1:0] seen;

    reset = 1'b0;
    init  = 1'b0;
    bus_if.src_we_addr = '0;
    bus_if.src_write   = '0;
    bus_if.src_addr    = '0;
    bus_if.src_data    = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_data", data_out, 0);
    check("rst_sw", sw_out, 0);
    check("rst_reset_out", reset_out, 0);
    check("rst_ack", bus_if.src_ack, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // address write from source 0, operand changed after grant
    run_single(0, 1'b1, 8'h35, 1'b0);
    // data write from source 1, request dropped before ack
    run_single(1, 1'b0, 8'hA5, 1'b1);

    // init clears addr only
    run_single(0, 1'b1, 8'h7F, 1'b0);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("init_addr", addr, 0);
    check("init_data", data_out, 8'hA5);
    check("init_ack", bus_if.src_ack, 0);
    check("init_busy", busy, 1);
    @(negedge clk);
    check("init_idle", busy, 0);

    // soft-reset trigger pair
    run_single(0, 1'b1, 8'h01, 1'b0);
    run_single(1, 1'b0, 8'h02, 1'b0);
    @(negedge clk);
    check("srst_addr", addr, 0);
    check("srst_data", data_out, 0);
    cnt = 0;
    while (reset_out === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("srst_len", cnt, 16);
    repeat (4) @(negedge clk);
    check("srst_no_retrig", reset_out, 0);
    check("srst_idle", busy, 0);

    // both sources requesting continuously
    bus_if.src_addr = {8'h20, 8'h10};
    ad_p[0] = 1'b1; ad_p[1] = 1'b1; wr_p[0] = 1'b0; wr_p[1] = 1'b0;
    bus_if.src_we_addr = 2'b11;
    for (int n = 0; n < 4; n++) begin
      s = pick_src();
      wait_ack(lat, ackv);
      check("cont_lat", lat, (n == 0) ? CYC : CYC + 1);
      check("cont_ack", ackv, 1 << s);
      check("cont_addr", addr, (s == 0) ? 8'h10 : 8'h20);
      note_grant(s);
    end
    bus_if.src_we_addr = 2'b00;
    ad_p[0] = 1'b0; ad_p[1] = 1'b0;
    @(negedge clk);
    check("cont_idle", busy, 0);

    // reset during the second write cycle aborts without ack
    bus_if.src_data[7:0] = 8'h5C;
    bus_if.src_write[0]  = 1'b1;
    @(negedge clk);
    check("abort_sw1", sw_out, 1);
    @(negedge clk);
    check("abort_sw2", sw_out, 1);
    #1;
    reset = 1'b0;
    bus_if.src_write[0] = 1'b0;
    #1;
    check("abort_sw_now", sw_out, 0);
    check("abort_busy_now", busy, 0);
    check("abort_data_now", data_out, 0);
    rr_next = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 2'b00;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus_if.src_ack;
    end
    check("abort_no_ack", seen, 0);
    check("abort_idle", busy, 0);

    // randomized batches against the reference model
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < NS; i++) begin
        ad_p[i] = 1'($urandom);
        wr_p[i] = 1'($urandom);
        av[i]   = 8'($urandom);
        if (av[i] == 8'h01) av[i] = 8'h81;
        dv[i]   = 8'($urandom);
        bus_if.src_we_addr[i]     = ad_p[i];
        bus_if.src_write[i]       = wr_p[i];
        bus_if.src_addr[i*8 +: 8] = av[i];
        bus_if.src_data[i*8 +: 8] = dv[i];
      end
      if (pick_src() < 0) begin
        ad_p[0] = 1'b1;
        bus_if.src_we_addr[0] = 1'b1;
      end
      first = 1'b1;
      while (pick_src() >= 0) begin
        s    = pick_src();
        is_a = ad_p[s];
        wait_ack(lat, ackv);
        check("rnd_lat", lat, first ? CYC : CYC + 1);
        first = 1'b0;
        check("rnd_ack", ackv, 1 << s);
        if (is_a) begin
          check("rnd_addr", addr, av[s]);
          ad_p[s] = 1'b0;
          bus_if.src_we_addr[s]     = 1'b0;
          bus_if.src_addr[s*8 +: 8] = 8'($urandom);
        end else begin
          check("rnd_data", data_out, dv[s]);
          check("rnd_sw", sw_out, 1);
          wr_p[s] = 1'b0;
          bus_if.src_write[s] = 1'b0;
        end
        note_grant(s);
        if (lat >= 20) break;
      end
      for (int i = 0; i < NS; i++) begin
        ad_p[i] = 1'b0;
        wr_p[i] = 1'b0;
      end
      bus_if.src_we_addr = '0;
      bus_if.src_write   = '0;
      @(negedge clk);
      check("rnd_idle", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
